// File: rtl/mul8_arbiter.sv
// Two-requester round-robin front end for a sequential shift-add multiplier.
// One operand pair is captured per grant; the product appears WIDTH cycles later.
module mul8_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     A0,
    input  logic [WIDTH-1:0]     B0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     A1,
    input  logic [WIDTH-1:0]     B1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 busy,
    output logic                 done,
    output logic                 done_id,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     p_q, p_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              owner_q, owner_d;
    logic              ptr_q, ptr_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done_q, done_d;
    logic              done_id_q, done_id_d;

    logic              pick1;
    logic [PW-1:0]     step_sum;

    // One multiplier bit per call: add the shifted multiplicand when that bit is set.
    function automatic logic [PW-1:0] shift_add(
        input logic [PW-1:0]    acc,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [CW-1:0]    step
    );
        logic [PW-1:0] addend;
        addend = {{WIDTH{1'b0}}, a} << step;
        if (b[step]) begin
            return acc + addend;
        end
        return acc;
    endfunction

    // ptr_q holds the last-served requester; under contention the other one wins.
    assign pick1    = req1 && (!req0 || !ptr_q);
    assign step_sum = shift_add(acc_q, a_q, b_q, cnt_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        p_d       = p_q;
        a_d       = a_q;
        b_d       = b_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = CALC;
                    a_d     = pick1 ? A1 : A0;
                    b_d     = pick1 ? B1 : B0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    owner_d = pick1;
                    ptr_d   = pick1;
                    gnt0_d  = !pick1;
                    gnt1_d  = pick1;
                end
            end
            CALC: begin
                acc_d = step_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    p_d       = step_sum;
                    done_id_d = owner_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            p_q       <= '0;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            p_q       <= p_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    // Operand copies are only meaningful after a capture, so they need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = (state_q == CALC);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign P       = p_q;

endmodule
